bram_req_ctrl: RTL

BRAM_REQ_CTRL -- requirements
Module: bram_req_ctrl

---
 rtl/bmem_pkg.sv | 12 +
 rtl/bram_rsp_fifo.sv | 81 ++++++++
 rtl/bram_req_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// Shared constants and helpers for the byte-enable BRAM request path.
package bmem_pkg;

  localparam int BYTE_NUM_DEF   = 4;
  localparam int BYTE_WIDTH_DEF = 8;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Read-response buffer: synchronous, count-based, registered pointers,
// combinational head output.
module bram_rsp_fifo
  import bmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
    // The upstream credit keeps the buffer from being full on a push;
    // the guard only protects stored data if that ever breaks.
    push_s   = push_i && ((count_q != CNT_FULL) || pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != {CNT_W{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/bram_req_ctrl.sv
// Request front-end for one port of a byte-enable BRAM with 1-cycle read
// latency; read data is captured into a credit-protected response FIFO.
module bram_req_ctrl
  import bmem_pkg::*;
#(
  parameter int BYTE_NUM   = BYTE_NUM_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WIDTH  = BYTE_NUM * BYTE_WIDTH,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [BYTE_NUM-1:0]   req_strb_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [MEM_WIDTH-1:0]  req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [MEM_WIDTH-1:0]  rsp_data_o,
  output logic                  mem_en_o,
  output logic [BYTE_NUM-1:0]   mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_WIDTH-1:0]  mem_data_o,
  input  logic [MEM_WIDTH-1:0]  mem_data_i,
  output logic                  busy_o
);

  localparam int CNT_W = cnt_width(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic             rd_pend_q, rd_pend_d;
  logic             acc_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] credit_s;

  // Accept, BRAM port drive and in-flight tracking. Credits count both
  // buffered entries and the read whose data lands next cycle, so a push
  // always has room; ready depends only on registers and reset.
  always_comb begin
    credit_s    = count_s + {{(CNT_W-1){1'b0}}, rd_pend_q};
    req_ready_o = ~rst_i && (credit_s < DEPTH_C);
    acc_s       = req_valid_i && req_ready_o;
    mem_en_o    = acc_s;
    if (acc_s && req_we_i) begin
      mem_wr_en_o = req_strb_i;
    end else begin
      mem_wr_en_o = {BYTE_NUM{1'b0}};
    end
    // A zero-strobe write makes the BRAM read, but it is not a read request.
    rd_pend_d = acc_s && !req_we_i;
  end

  // In-flight read flag, high for exactly the cycle after a read accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign mem_addr_o = req_addr_i;
  assign mem_data_o = req_data_i;
  assign busy_o     = rd_pend_q || (count_s != {CNT_W{1'b0}});

  bram_rsp_fifo #(
    .WIDTH (MEM_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rd_pend_q),
    .data_i  (mem_data_i),
    .pop_i   (rsp_ready_i),
    .data_o  (rsp_data_o),
    .valid_o (rsp_valid_o),
    .count_o (count_s)
  );

endmodule
